ncpu32k_regf_wb_arb: RTL and testbench
======================================

NCPU32K_REGF_WB_ARB -- requirements
Module: ncpu32k_regf_wb_arb

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NREQ, 3, number of writeback requesters; AW, `NCPU_REG_AW, register address width; DW, `NCPU_DW, data width.
REQ-002 The block SHALL have a single clock `clk` and a synchronous, active-low reset `rst_n`; all state SHALL update only on the rising edge of `clk`.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wb_valid  in  NREQ  requester i has a write pending
- wb_ready  out  NREQ  requester i is accepted this cycle
- wb_addr  in  NREQ*AW  destination register; slice i belongs to requester i
- wb_dat  in  NREQ*DW  write data; slice i belongs to requester i
- flush  in  1  discard speculative state
- sb_set_valid  in  1  issue stage marks a register pending
- sb_set_addr  in  AW  register to mark pending
- sb_rs1_addr, sb_rs2_addr  in  AW each  operand addresses to check
- sb_rs1_busy, sb_rs2_busy  out  1 each  operand register is pending
- sb_rd_busy  out  1  sb_set_addr is already pending (WAW hazard)
- regf_we  out  1  write enable to the regfile
- regf_din_addr  out  AW  regfile write address
- regf_din  out  DW  regfile write data

Function
REQ-004 Arbitration SHALL be round-robin: the grant goes to the first requester with wb_valid=1, searching from index rr_ptr upward with wrap-around.
REQ-005 wb_ready SHALL be one-hot or all-zero, and SHALL be combinational from wb_valid, rr_ptr and flush.
REQ-006 A transfer SHALL occur when wb_valid[i] & wb_ready[i] are both 1.
REQ-007 When no requester is valid, wb_ready SHALL be all-zero.
REQ-008 After a transfer by requester i, rr_ptr SHALL become (i+1) mod NREQ; with no transfer, rr_ptr SHALL hold.
REQ-009 The winning addr/dat SHALL be registered, so the regfile write occurs 1 cycle after acceptance (regf_we, regf_din_addr, regf_din are register outputs).
REQ-010 regf_we SHALL be asserted only for an accepted transfer with nonzero addr; an addr-0 transfer SHALL be accepted and dropped.
REQ-011 The write pipeline SHALL never apply backpressure: one accepted transfer per cycle sustained.
REQ-012 The scoreboard SHALL consist of busy[2^AW-1:1] registers, with busy[0] hardwired to 0.
REQ-013 sb_set_valid with sb_set_addr != 0 SHALL set busy[sb_set_addr] at the next edge.
REQ-014 regf_we=1 SHALL clear busy[regf_din_addr] at the same edge the regfile writes.
REQ-015 When a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-016 Busy outputs SHALL be computed combinationally:
- sb_rsN_busy = busy[sb_rsN_addr] & ~(regf_we & regf_din_addr == sb_rsN_addr), relying on the regfile write-read bypass;
- sb_rd_busy = busy[sb_set_addr], with the same masking.
REQ-017 While flush=1:
- wb_ready SHALL be all-zero;
- regf_we SHALL be 0 at the next edge;
- all busy bits SHALL be cleared at the next edge;
- sb_set_valid SHALL be ignored;
- rr_ptr SHALL hold.
REQ-018 A write already in the output register when flush rises SHALL still complete; flush does not cancel it.

Reset
REQ-019 While rst_n=0 at an edge, the block SHALL reset to: regf_we=0, regf_din_addr=0, regf_din=0, rr_ptr=0, all busy=0.
REQ-020 While rst_n=0, wb_ready SHALL be all-zero and an in-flight request SHALL be discarded.

Structure
REQ-021 AW and DW SHALL come from the shared ncpu32k_config.h macros; NREQ stays a local parameter.
REQ-022 The round-robin grant logic SHALL be a reusable sub-module, ncpu32k_cell_rr_arb, parameterised by N.
REQ-023 The scoreboard and output register SHALL reside in the top module.

Verification
REQ-024 Reset, then wb_valid=3'b111 held for 6 cycles -> grants rotate 0,1,2,0,1,2; each regf_we follows its accept by 1 cycle with the matching addr/dat.
REQ-025 Set r5, then requester 1 writes r5=0x1234_5678 -> sb_rs1_busy(r5) is 1 until the regf_we cycle, 0 in the regf_we cycle, and a regfile read returns 0x1234_5678.
REQ-026 sb_set_valid r7 and regf_we r7 in the same cycle -> busy[7]=1 afterwards.
REQ-027 Write to r0 with data 0xFFFF_FFFF -> wb_ready=1, regf_we stays 0, busy[0] stays 0.
REQ-028 flush with busy r3/r9 set and requester 2 valid -> wb_ready=0; both busy bits clear the next cycle; the pending output write still completes.
REQ-029 Assert rst_n=0 mid-burst -> all outputs return to 0 at the next edge and the arbiter restarts at requester 0.

Source files
------------

// File: rtl/ncpu32k_regf_wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// ncpu32k_regf_wb_arb_pkg
//   Shared core configuration for the regfile writeback path: register address
//   width, data width, default requester count and small helpers used by the
//   arbiter and its round-robin cell.
// ----------------------------------------------------------------------------
package ncpu32k_regf_wb_arb_pkg;

  localparam int NCPU_REG_AW = 5;    // 32 architectural registers
  localparam int NCPU_DW     = 32;   // datapath width
  localparam int NREQ_DEF    = 3;    // default number of writeback requesters

  // Width of a round-robin pointer over n requesters (at least one bit).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next round-robin start position after requester idx was served.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ncpu32k_regf_wb_arb_if.sv
// ----------------------------------------------------------------------------
// ncpu32k_regf_wb_arb_if
//   Writeback request bus between the execution units and the regfile
//   writeback arbiter. Slice i of wb_addr/wb_dat belongs to requester i.
//   master : requester side (drives valid/addr/dat, sees ready)
//   slave  : arbiter side   (sees valid/addr/dat, drives ready)
// ----------------------------------------------------------------------------
interface ncpu32k_regf_wb_arb_if
  import ncpu32k_regf_wb_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = NCPU_REG_AW,
  parameter int DW   = NCPU_DW
);
  logic [NREQ-1:0]    wb_valid;
  logic [NREQ-1:0]    wb_ready;
  logic [NREQ*AW-1:0] wb_addr;
  logic [NREQ*DW-1:0] wb_dat;

  modport master (output wb_valid, output wb_addr, output wb_dat, input  wb_ready);
  modport slave  (input  wb_valid, input  wb_addr, input  wb_dat, output wb_ready);
endinterface

// File: rtl/ncpu32k_cell_rr_arb.sv
// ----------------------------------------------------------------------------
// ncpu32k_cell_rr_arb
//   Purely combinational round-robin grant: picks the first valid requester
//   searching upward from ptr with wrap-around.
//   valid     : request vector
//   ptr       : search start index
//   grant     : one-hot grant (all-zero when nothing is valid)
//   grant_idx : binary index of the granted requester (0 when none)
//   grant_any : some requester was granted
// ----------------------------------------------------------------------------
module ncpu32k_cell_rr_arb
  import ncpu32k_regf_wb_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_any
);

  logic [PW-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sel       = '0;
    for (int k = 0; k < N; k++) begin
      sel = PW'((int'(ptr) + k) % N);
      if (!grant_any && valid[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ncpu32k_regf_wb_arb.sv
// ----------------------------------------------------------------------------
// ncpu32k_regf_wb_arb
//   Regfile writeback arbiter with register scoreboard.
//   clk, rst_n          : clock, synchronous active-low reset
//   wb (slave)          : NREQ writeback requesters, round-robin arbitrated
//   flush               : drop speculative state (busy bits, new accepts)
//   sb_set_valid/addr   : issue stage marks a destination register pending
//   sb_rs1/rs2_addr     : operand registers to check
//   sb_rs1/rs2/rd_busy  : pending status (bypass-masked against the write)
//   regf_we/din_addr/din: registered regfile write port, one cycle after accept
// ----------------------------------------------------------------------------
module ncpu32k_regf_wb_arb
  import ncpu32k_regf_wb_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = NCPU_REG_AW,
  parameter int DW   = NCPU_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ncpu32k_regf_wb_arb_if.slave   wb,
  input  logic                   flush,
  input  logic                   sb_set_valid,
  input  logic [AW-1:0]          sb_set_addr,
  input  logic [AW-1:0]          sb_rs1_addr,
  input  logic [AW-1:0]          sb_rs2_addr,
  output logic                   sb_rs1_busy,
  output logic                   sb_rs2_busy,
  output logic                   sb_rd_busy,
  output logic                   regf_we,
  output logic [AW-1:0]          regf_din_addr,
  output logic [DW-1:0]          regf_din
);

  localparam int PW   = ptr_w(NREQ);
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            regf_we_q, regf_we_d;
  logic [AW-1:0]   regf_din_addr_q, regf_din_addr_d;
  logic [DW-1:0]   regf_din_q, regf_din_d;
  logic [NREG-1:1] busy_q, busy_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic            accept;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_dat;
  logic [NREG-1:0] busy_full;

  ncpu32k_cell_rr_arb #(.N(NREQ), .PW(PW)) u_rr_arb (
    .valid     (wb.wb_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Nothing is accepted during reset or flush, so the pointer holds there too.
  assign accept      = grant_any & rst_n & ~flush;
  assign wb.wb_ready = accept ? grant : '0;
  assign win_addr    = wb.wb_addr[int'(grant_idx)*AW +: AW];
  assign win_dat     = wb.wb_dat[int'(grant_idx)*DW +: DW];

  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    regf_we_d       = 1'b0;
    regf_din_addr_d = regf_din_addr_q;
    regf_din_d      = regf_din_q;
    if (accept) begin
      rr_ptr_d        = PW'(rr_next(int'(grant_idx), NREQ));
      // r0 writes are consumed but never reach the regfile.
      regf_we_d       = (win_addr != '0);
      regf_din_addr_d = win_addr;
      regf_din_d      = win_dat;
    end
  end

  // Clear on writeback first, then set, so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (regf_we_q && regf_din_addr_q == AW'(r))
        busy_d[r] = 1'b0;
      if (sb_set_valid && sb_set_addr == AW'(r))
        busy_d[r] = 1'b1;
      if (flush)
        busy_d[r] = 1'b0;
    end
  end

  // Register 0 is never pending; the write being applied this cycle is
  // visible through the regfile bypass, so it masks its own busy bit.
  assign busy_full   = {busy_q, 1'b0};
  assign sb_rs1_busy = busy_full[sb_rs1_addr] & ~(regf_we_q && regf_din_addr_q == sb_rs1_addr);
  assign sb_rs2_busy = busy_full[sb_rs2_addr] & ~(regf_we_q && regf_din_addr_q == sb_rs2_addr);
  assign sb_rd_busy  = busy_full[sb_set_addr] & ~(regf_we_q && regf_din_addr_q == sb_set_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q        <= '0;
      regf_we_q       <= 1'b0;
      regf_din_addr_q <= '0;
      regf_din_q      <= '0;
      busy_q          <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      regf_we_q       <= regf_we_d;
      regf_din_addr_q <= regf_din_addr_d;
      regf_din_q      <= regf_din_d;
      busy_q          <= busy_d;
    end
  end

  assign regf_we       = regf_we_q;
  assign regf_din_addr = regf_din_addr_q;
  assign regf_din      = regf_din_q;

endmodule

// File: tb/tb_ncpu32k_regf_wb_arb.sv
module tb_ncpu32k_regf_wb_arb;
  import ncpu32k_regf_wb_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = NCPU_REG_AW;
  localparam int DW   = NCPU_DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush;
  logic          sb_set_valid;
  logic [AW-1:0] sb_set_addr, sb_rs1_addr, sb_rs2_addr;
  logic          sb_rs1_busy, sb_rs2_busy, sb_rd_busy;
  logic          regf_we;
  logic [AW-1:0] regf_din_addr;
  logic [DW-1:0] regf_din;

  ncpu32k_regf_wb_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) wb_if ();

  ncpu32k_regf_wb_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb            (wb_if.slave),
    .flush         (flush),
    .sb_set_valid  (sb_set_valid),
    .sb_set_addr   (sb_set_addr),
    .sb_rs1_addr   (sb_rs1_addr),
    .sb_rs2_addr   (sb_rs2_addr),
    .sb_rs1_busy   (sb_rs1_busy),
    .sb_rs2_busy   (sb_rs2_busy),
    .sb_rd_busy    (sb_rd_busy),
    .regf_we       (regf_we),
    .regf_din_addr (regf_din_addr),
    .regf_din      (regf_din)
  );

  // Regfile model fed by the write port.
  logic [DW-1:0] rf [0:(1<<AW)-1];
  always @(posedge clk) if (regf_we) rf[regf_din_addr] <= regf_din;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic        flush;
    logic [14:0] addr;    // {a2,a1,a0}
    logic [95:0] dat;     // {d2,d1,d0}
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_dat;
  } vec_t;

  localparam logic [14:0] A_STD = {5'd12, 5'd11, 5'd10};
  localparam logic [95:0] D_STD = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

  vec_t vecs [14];

  function automatic vec_t mk(input logic [2:0] v, input logic f, input logic [14:0] a,
                              input logic [95:0] d, input logic [2:0] er, input logic ew,
                              input logic [4:0] ea, input logic [31:0] ed);
    vec_t t;
    t.valid = v; t.flush = f; t.addr = a; t.dat = d;
    t.exp_ready = er; t.exp_we = ew; t.exp_addr = ea; t.exp_dat = ed;
    return t;
  endfunction

  initial begin
    // Rotation after reset (ptr starts at 0), then partial-valid patterns.
    vecs[0]  = mk(3'b111, 0, A_STD, D_STD, 3'b001, 1, 5'd10, 32'hAAAA_0000);
    vecs[1]  = mk(3'b111, 0, A_STD, D_STD, 3'b010, 1, 5'd11, 32'hBBBB_0001);
    vecs[2]  = mk(3'b111, 0, A_STD, D_STD, 3'b100, 1, 5'd12, 32'hCCCC_0002);
    vecs[3]  = mk(3'b111, 0, A_STD, D_STD, 3'b001, 1, 5'd10, 32'hAAAA_0000);
    vecs[4]  = mk(3'b111, 0, A_STD, D_STD, 3'b010, 1, 5'd11, 32'hBBBB_0001);
    vecs[5]  = mk(3'b111, 0, A_STD, D_STD, 3'b100, 1, 5'd12, 32'hCCCC_0002);
    vecs[6]  = mk(3'b000, 0, A_STD, D_STD, 3'b000, 0, 5'd0,  32'h0);          // ptr 0
    vecs[7]  = mk(3'b101, 0, A_STD, D_STD, 3'b001, 1, 5'd10, 32'hAAAA_0000);  // ptr 0 -> 1
    vecs[8]  = mk(3'b101, 0, A_STD, D_STD, 3'b100, 1, 5'd12, 32'hCCCC_0002);  // ptr 1 -> 0
    vecs[9]  = mk(3'b110, 0, A_STD, D_STD, 3'b010, 1, 5'd11, 32'hBBBB_0001);  // ptr 0 -> 2
    vecs[10] = mk(3'b011, 0, A_STD, D_STD, 3'b001, 1, 5'd10, 32'hAAAA_0000);  // ptr 2 wraps -> 1
    vecs[11] = mk(3'b111, 1, A_STD, D_STD, 3'b000, 0, 5'd0,  32'h0);          // flush: ptr holds 1
    vecs[12] = mk(3'b111, 0, A_STD, D_STD, 3'b010, 1, 5'd11, 32'hBBBB_0001);  // ptr 1 -> 2
    vecs[13] = mk(3'b100, 0, {5'd0, 5'd11, 5'd10},
                  {32'hFFFF_FFFF, 32'hBBBB_0001, 32'hAAAA_0000},
                  3'b100, 0, 5'd0, 32'h0);                                    // r0 write dropped

    rst_n = 1'b0; flush = 1'b0; sb_set_valid = 1'b0;
    sb_set_addr = '0; sb_rs1_addr = '0; sb_rs2_addr = '0;
    wb_if.wb_valid = 3'b111; wb_if.wb_addr = A_STD; wb_if.wb_dat = D_STD;

    // Reset state
    #1;
    chk("reset_ready", wb_if.wb_ready, 3'b000);
    tick(); tick();
    chk("reset_we", regf_we, 1'b0);
    chk("reset_addr", regf_din_addr, 5'd0);
    chk("reset_dat", regf_din, 32'h0);
    chk("reset_ready2", wb_if.wb_ready, 3'b000);
    rst_n = 1'b1;
    wb_if.wb_valid = 3'b000;
    tick();

    // Table
    for (int i = 0; i < 14; i++) begin
      wb_if.wb_valid = vecs[i].valid;
      flush          = vecs[i].flush;
      wb_if.wb_addr  = vecs[i].addr;
      wb_if.wb_dat   = vecs[i].dat;
      #1;
      chk($sformatf("vec%0d_ready", i), wb_if.wb_ready, vecs[i].exp_ready);
      tick();
      chk($sformatf("vec%0d_we", i), regf_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d_addr", i), regf_din_addr, vecs[i].exp_addr);
        chk($sformatf("vec%0d_dat", i), regf_din, vecs[i].exp_dat);
      end
    end
    wb_if.wb_valid = 3'b000; flush = 1'b0;

    // r0 is never busy, even when the issue stage tries to set it
    sb_set_valid = 1'b1; sb_set_addr = 5'd0;
    tick();
    sb_set_valid = 1'b0; sb_rs1_addr = 5'd0;
    #1;
    chk("r0_busy", sb_rs1_busy, 1'b0);

    // Set r5, requester 1 writes r5
    sb_set_valid = 1'b1; sb_set_addr = 5'd5;
    tick();
    sb_set_valid = 1'b0; sb_rs1_addr = 5'd5; sb_rs2_addr = 5'd5;
    #1;
    chk("r5_rs1_busy_set", sb_rs1_busy, 1'b1);
    chk("r5_rs2_busy_set", sb_rs2_busy, 1'b1);
    chk("r5_rd_busy_set", sb_rd_busy, 1'b1);
    wb_if.wb_valid = 3'b010;
    wb_if.wb_addr  = {5'd12, 5'd5, 5'd10};
    wb_if.wb_dat   = {32'hCCCC_0002, 32'h1234_5678, 32'hAAAA_0000};
    #1;
    chk("r5_ready", wb_if.wb_ready, 3'b010);
    chk("r5_busy_accept", sb_rs1_busy, 1'b1);
    tick();
    wb_if.wb_valid = 3'b000;
    #1;
    chk("r5_we", regf_we, 1'b1);
    chk("r5_waddr", regf_din_addr, 5'd5);
    chk("r5_busy_bypass", sb_rs1_busy, 1'b0);
    chk("r5_rd_busy_bypass", sb_rd_busy, 1'b0);
    tick();
    chk("r5_busy_after", sb_rs1_busy, 1'b0);
    chk("r5_rf_read", rf[5], 32'h1234_5678);

    // Set and clear of r7 in the same cycle: set wins
    sb_set_valid = 1'b1; sb_set_addr = 5'd7;
    tick();
    sb_set_valid = 1'b0;
    wb_if.wb_valid = 3'b001;
    wb_if.wb_addr  = {5'd12, 5'd11, 5'd7};
    wb_if.wb_dat   = {32'hCCCC_0002, 32'hBBBB_0001, 32'h7777_7777};
    tick();
    wb_if.wb_valid = 3'b000;
    sb_set_valid = 1'b1; sb_set_addr = 5'd7;
    #1;
    chk("r7_we", regf_we, 1'b1);
    tick();
    sb_set_valid = 1'b0; sb_rs1_addr = 5'd7;
    #1;
    chk("r7_rs1_busy", sb_rs1_busy, 1'b1);
    chk("r7_rd_busy", sb_rd_busy, 1'b1);

    // Flush with r3/r9 busy, a write in the output register, requester 2 valid
    sb_set_valid = 1'b1; sb_set_addr = 5'd3;
    tick();
    sb_set_addr = 5'd9;
    tick();
    sb_set_valid = 1'b0;
    wb_if.wb_valid = 3'b001;
    wb_if.wb_addr  = {5'd12, 5'd11, 5'd20};
    wb_if.wb_dat   = {32'hCCCC_0002, 32'hBBBB_0001, 32'hDEAD_BEEF};
    tick();
    sb_rs1_addr = 5'd3; sb_rs2_addr = 5'd9;
    flush = 1'b1; wb_if.wb_valid = 3'b100;
    sb_set_valid = 1'b1; sb_set_addr = 5'd4;
    #1;
    chk("flush_r3_busy_before", sb_rs1_busy, 1'b1);
    chk("flush_r9_busy_before", sb_rs2_busy, 1'b1);
    chk("flush_ready", wb_if.wb_ready, 3'b000);
    chk("flush_pending_we", regf_we, 1'b1);
    tick();
    flush = 1'b0; wb_if.wb_valid = 3'b000; sb_set_valid = 1'b0;
    #1;
    chk("flush_r3_clear", sb_rs1_busy, 1'b0);
    chk("flush_r9_clear", sb_rs2_busy, 1'b0);
    chk("flush_set_ignored", sb_rd_busy, 1'b0);
    chk("flush_we_after", regf_we, 1'b0);
    chk("flush_pending_done", rf[20], 32'hDEAD_BEEF);

    // Reset mid-burst
    sb_set_valid = 1'b1; sb_set_addr = 5'd6;
    tick();
    sb_set_valid = 1'b0;
    wb_if.wb_valid = 3'b111; wb_if.wb_addr = A_STD; wb_if.wb_dat = D_STD;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", wb_if.wb_ready, 3'b000);
    tick();
    chk("midrst_we", regf_we, 1'b0);
    chk("midrst_addr", regf_din_addr, 5'd0);
    chk("midrst_dat", regf_din, 32'h0);
    rst_n = 1'b1; sb_rs1_addr = 5'd6;
    #1;
    chk("midrst_r6_clear", sb_rs1_busy, 1'b0);
    chk("midrst_restart", wb_if.wb_ready, 3'b001);
    tick();
    chk("midrst_restart_addr", regf_din_addr, 5'd10);
    chk("midrst_restart_we", regf_we, 1'b1);
    wb_if.wb_valid = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
